// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 subtract datapath: operand view,
// pipeline stage registers and the significand decode helper.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int SIG_W = MAN_W + 1;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;
    localparam logic [15:0]      QNAN    = 16'h7E00;
    localparam logic [15:0]      POS_INF = 16'h7C00;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig_a;
        logic [SIG_W-1:0] sig_b;
        logic             eff_sub;
        logic             invalid;
    } s1_reg_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W:0]   sum;
        logic             invalid;
    } s2_reg_t;

    typedef struct packed {
        logic [15:0] diff;
        logic        overflow;
        logic        underflow;
        logic        invalid;
    } s3_reg_t;

    // Zero exponent means the operand is zero, so denormal mantissas are dropped.
    function automatic logic [SIG_W-1:0] significand(input fp16_t f);
        return (f.exp != 5'd0) ? {1'b1, f.man} : 11'd0;
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// 12-bit leading-zero counter used by the normalize stage; all-zero input gives 12.
module fp16_lzc (
    input  logic [11:0] value_i,
    output logic [3:0]  count_o
);

    // Highest set bit wins because the scan runs upward and later hits overwrite.
    always_comb begin
        count_o = 4'd12;
        for (int i = 0; i < 12; i++) begin
            count_o = value_i[i] ? 4'(11 - i) : count_o;
        end
    end

endmodule

// File: rtl/fp16_subtractor_pipe.sv
// Three-stage FP16 subtractor (align, magnitude add/sub, normalize/pack) with
// valid/ready on both sides; the whole pipe advances as one on a free output slot.
module fp16_subtractor_pipe
    import fp16_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clock_80,
    input  logic                   reset_80,
    input  logic [EXP_W+MAN_W:0]   input_1_80,
    input  logic [EXP_W+MAN_W:0]   input_2_80,
    input  logic                   in_valid_80,
    output logic                   in_ready_80,
    output logic [EXP_W+MAN_W:0]   diff_80,
    output logic                   out_valid_80,
    input  logic                   out_ready_80,
    output logic                   overflow_80,
    output logic                   underflow_80,
    output logic                   invalid_80
);

    logic          advance_s;
    fp16_t         op1_s;
    fp16_t         op2_s;
    fp16_t         big_s;
    fp16_t         small_s;
    logic [4:0]    exp_diff_s;
    logic [10:0]   sig_small_s;
    logic [3:0]    lzc_s;
    logic [9:0]    norm_man_s;
    logic signed [6:0] exp_norm_s;

    s1_reg_t s1_d, s1_q;
    s2_reg_t s2_d, s2_q;
    s3_reg_t s3_d, s3_q;
    logic    v1_q, v2_q, out_valid_q;

    assign advance_s   = ~out_valid_q | out_ready_80;
    assign in_ready_80 = advance_s;

    // S1: invert the subtrahend sign, order by magnitude, align the smaller significand.
    always_comb begin
        op1_s = input_1_80;
        op2_s = {~input_2_80[15], input_2_80[14:0]};
        if ({op1_s.exp, op1_s.man} >= {op2_s.exp, op2_s.man}) begin
            big_s   = op1_s;
            small_s = op2_s;
        end else begin
            big_s   = op2_s;
            small_s = op1_s;
        end
        exp_diff_s    = big_s.exp - small_s.exp;
        sig_small_s   = significand(small_s);
        s1_d.sign     = big_s.sign;
        s1_d.exp      = big_s.exp;
        s1_d.sig_a    = significand(big_s);
        s1_d.sig_b    = (exp_diff_s >= 5'd11) ? 11'd0 : (sig_small_s >> exp_diff_s);
        s1_d.eff_sub  = big_s.sign ^ small_s.sign;
        s1_d.invalid  = (op1_s.exp == EXP_MAX) || (op2_s.exp == EXP_MAX);
    end

    // S2: magnitude sum or difference; the swap keeps the difference non-negative.
    always_comb begin
        s2_d.sign    = s1_q.sign;
        s2_d.exp     = s1_q.exp;
        s2_d.invalid = s1_q.invalid;
        if (s1_q.eff_sub) begin
            s2_d.sum = {1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b};
        end else begin
            s2_d.sum = {1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b};
        end
    end

    fp16_lzc u_lzc (
        .value_i (s2_q.sum),
        .count_o (lzc_s)
    );

    // S3: normalize with a widened signed exponent so over/underflow cannot wrap.
    always_comb begin
        s3_d = '0;
        if (s2_q.sum[11]) begin
            norm_man_s = 10'(s2_q.sum >> 1);
            exp_norm_s = $signed({2'b00, s2_q.exp}) + 7'sd1;
        end else begin
            norm_man_s = 10'(s2_q.sum << (lzc_s - 4'd1));
            exp_norm_s = $signed({2'b00, s2_q.exp}) - $signed({3'b000, lzc_s}) + 7'sd1;
        end
        if (s2_q.invalid) begin
            s3_d.diff    = QNAN;
            s3_d.invalid = 1'b1;
        end else if (s2_q.sum == 12'd0) begin
            s3_d.diff = 16'h0000;
        end else if (exp_norm_s >= 7'sd31) begin
            s3_d.diff     = {s2_q.sign, POS_INF[14:0]};
            s3_d.overflow = 1'b1;
        end else if (exp_norm_s <= 7'sd0) begin
            s3_d.diff      = 16'h0000;
            s3_d.underflow = 1'b1;
        end else begin
            s3_d.diff = {s2_q.sign, exp_norm_s[4:0], norm_man_s};
        end
    end

    // Stage registers: reset drops everything in flight; a stall freezes all stages.
    always_ff @(posedge clock_80) begin
        if (reset_80) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
        end else if (advance_s) begin
            v1_q        <= in_valid_80;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
        end else begin
            v1_q        <= v1_q;
            v2_q        <= v2_q;
            out_valid_q <= out_valid_q;
            s1_q        <= s1_q;
            s2_q        <= s2_q;
            s3_q        <= s3_q;
        end
    end

    assign out_valid_80 = out_valid_q;
    assign diff_80      = s3_q.diff;
    assign overflow_80  = s3_q.overflow;
    assign underflow_80 = s3_q.underflow;
    assign invalid_80   = s3_q.invalid;

endmodule

// File: tb/tb_fp16_subtractor_pipe.sv
// Scoreboard bench for fp16_subtractor_pipe: directed cases plus random operands
// checked against an integer reference model of FP16 subtraction.
module tb_fp16_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b, diff;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        ovf, unf, inv;

    always #5 clk = ~clk;

    fp16_subtractor_pipe dut (
        .clock_80     (clk),
        .reset_80     (rst),
        .input_1_80   (a),
        .input_2_80   (b),
        .in_valid_80  (in_valid),
        .in_ready_80  (in_ready),
        .diff_80      (diff),
        .out_valid_80 (out_valid),
        .out_ready_80 (out_ready),
        .overflow_80  (ovf),
        .underflow_80 (unf),
        .invalid_80   (inv)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [18:0] res;
    } stim_t;

    typedef struct {
        logic [18:0] res;
        int          issue_cyc;
        bit          chk_lat;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: {diff, overflow, underflow, invalid} from plain integer arithmetic.
    function automatic logic [18:0] ref_sub(input logic [15:0] x, input logic [15:0] y);
        int ex, ey, mx, my, sx, sy, ea, eb, sa, sb, sgn, d, sum, e;
        logic [15:0] r;
        ex = int'(x[14:10]); mx = int'(x[9:0]); sx = int'(x[15]);
        ey = int'(y[14:10]); my = int'(y[9:0]); sy = 1 - int'(y[15]);
        if (ex == 31 || ey == 31) return {16'h7E00, 3'b001};
        if (ex * 1024 + mx >= ey * 1024 + my) begin
            ea = ex; sa = (ex != 0) ? 1024 + mx : 0; sgn = sx;
            eb = ey; sb = (ey != 0) ? 1024 + my : 0;
        end else begin
            ea = ey; sa = (ey != 0) ? 1024 + my : 0; sgn = sy;
            eb = ex; sb = (ex != 0) ? 1024 + mx : 0;
        end
        d   = ea - eb;
        sb  = (d >= 11) ? 0 : (sb >> d);
        sum = (sx == sy) ? sa + sb : sa - sb;
        if (sum == 0) return {16'h0000, 3'b000};
        e = ea;
        while (sum >= 2048) begin sum = sum / 2; e++; end
        while (sum < 1024)  begin sum = sum * 2; e--; end
        if (e >= 31) return {(sgn != 0) ? 16'hFC00 : 16'h7C00, 3'b100};
        if (e <= 0)  return {16'h0000, 3'b010};
        r = 16'(sgn * 32768 + e * 1024 + (sum - 1024));
        return {r, 3'b000};
    endfunction

    task automatic add_dir(input logic [15:0] x, input logic [15:0] y, input logic [15:0] d, input logic [2:0] f);
        stim_t s;
        s.a = x; s.b = y; s.res = {d, f};
        stim_q.push_back(s);
    endtask

    task automatic add_rand(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s.a = 16'($urandom);
            if ($urandom_range(1) == 1) s.b = 16'($urandom);
            else s.b = {1'($urandom), s.a[14:0] ^ 15'($urandom_range(0, 2047))};
            s.res = ref_sub(s.a, s.b);
            stim_q.push_back(s);
        end
    endtask

    // Feed stim_q; out_ready is low on cycles stall_lo..stall_hi, or random if rnd.
    task automatic drive_stream(input int stall_lo, input int stall_hi, input bit rnd, input bit lat_chk);
        int   c = 0;
        exp_t e;
        while (stim_q.size() > 0) begin
            @(negedge clk);
            c++;
            out_ready = rnd ? ($urandom_range(3) != 0) : !(c >= stall_lo && c <= stall_hi);
            a = stim_q[0].a;
            b = stim_q[0].b;
            in_valid = 1'b1;
            #1;
            if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
            if (in_ready) begin
                e.res = stim_q[0].res; e.issue_cyc = cyc; e.chk_lat = lat_chk;
                exp_q.push_back(e);
                void'(stim_q.pop_front());
            end
        end
        for (int t = 0; t < 300 && exp_q.size() > 0; t++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: pops on each transfer, and checks outputs hold during a stall.
    initial begin
        logic [18:0] held = '0;
        bit          stalled = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (stalled && !rst) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", {diff, ovf, unf, inv}, held);
            end
            stalled = out_valid && !out_ready && !rst;
            held    = {diff, ovf, unf, inv};
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {diff, ovf, unf, inv}, 0);
                    check("unexpected_output_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {diff, ovf, unf, inv}, e.res);
                    if (e.chk_lat) check("latency", cyc - e.issue_cyc, 3);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 16'h0; b = 16'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_diff", diff, 16'h0000);
        check("reset_flags", {ovf, unf, inv}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);

        // Directed cases, back to back with no stall.
        add_dir(16'h4200, 16'h3C00, 16'h4000, 3'b000);
        add_dir(16'h3C00, 16'h4200, 16'hC000, 3'b000);
        add_dir(16'h3E00, 16'hBE00, 16'h4200, 3'b000);
        add_dir(16'h3C00, 16'h3C00, 16'h0000, 3'b000);
        add_dir(16'h3C00, 16'h3BFF, 16'h1400, 3'b000);
        add_dir(16'h7BFF, 16'hFBFF, 16'h7C00, 3'b100);
        add_dir(16'h0401, 16'h0400, 16'h0000, 3'b010);
        add_dir(16'h7C00, 16'h3C00, 16'h7E00, 3'b001);
        add_dir(16'h0000, 16'h3C00, 16'hBC00, 3'b000);
        add_dir(16'h3C00, 16'h7FFF, 16'h7E00, 3'b001);
        drive_stream(0, -1, 1'b0, 1'b1);

        // Six back-to-back operations with the output stalled on cycles 3-6.
        add_rand(6);
        drive_stream(3, 6, 1'b0, 1'b0);

        // Reset with three operations in flight: all of them must vanish.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_diff", diff, 16'h0000);
        repeat (10) @(negedge clk);
        check("midreset_no_stale", exp_q.size(), 0);

        // Random traffic: first at full rate with latency checks, then random backpressure.
        add_rand(100);
        drive_stream(0, -1, 1'b0, 1'b1);
        add_rand(300);
        drive_stream(0, -1, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
